// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants and the jump state enum
package game_pkg;

    typedef enum logic [1:0] {
        GROUNDED,
        RISING,
        FALLING
    } jump_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_H = 96;
    localparam int FEET_Y   = 456;

    localparam int DEFAULT_GROUND_Y = FEET_Y - SPRITE_H;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - 2-FF synchronizer plus rising-edge detect for a raw button
module btn_sync_edge (
    input  logic pix_clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/player_jump_ctrl.sv
// rtl/player_jump_ctrl.sv - once-per-frame jump/gravity FSM for player_y; PLAYER_DOUBLE_JUMP_EN adds one mid-air relaunch
module player_jump_ctrl
    import game_pkg::*;
#(
    parameter int GROUND_Y    = DEFAULT_GROUND_Y,
    parameter int CEIL_Y      = 0,
    parameter int JUMP_VEL    = 12,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 15,
    parameter int UPDATE_LINE = 480
) (
    input  logic       pix_clk,
    input  logic       rst,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       jump_btn,
    output logic [9:0] player_y,
    output logic       airborne,
    output logic       jump_pulse,
    output logic       land_pulse
);

    localparam logic signed [11:0] GROUND_S   = 12'(GROUND_Y);
    localparam logic signed [11:0] CEIL_S     = 12'(CEIL_Y);
    localparam logic signed [11:0] JUMP_S     = 12'(JUMP_VEL);
    localparam logic signed [8:0]  GRAV_S     = 9'(GRAVITY);
    localparam logic signed [8:0]  FALL_LIM   = 9'(-MAX_FALL);
    localparam logic signed [7:0]  LAUNCH_VEL = 8'(JUMP_VEL - GRAVITY);

    jump_state_t        state;
    logic signed [10:0] y;
    logic signed [7:0]  vel;
    logic               jump_req;
    logic               btn_rise;
    logic               frame_tick;
    logic               req;
    logic signed [11:0] y_ext;
    logic signed [11:0] y_n;
    logic signed [11:0] y_up;
    logic signed [11:0] y_jump;
    logic signed [8:0]  vel_dec;
    logic signed [7:0]  vel_n;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic               dj_used;
`endif

    btn_sync_edge u_jump_btn (
        .pix_clk (pix_clk),
        .rst     (rst),
        .btn     (jump_btn),
        .rise    (btn_rise)
    );

    assign frame_tick = (hcount == 10'd0) && (vcount == 10'(UPDATE_LINE));
    // An edge landing on the tick cycle itself still launches this frame.
    assign req        = jump_req | btn_rise;
    assign player_y   = y[9:0];

    // Velocity math is one bit wider so the gravity step cannot wrap below -128.
    always_comb begin
        y_ext   = {y[10], y};
        y_n     = y_ext - {{4{vel[7]}}, vel};
        vel_dec = {vel[7], vel} - GRAV_S;
        vel_n   = (vel_dec < FALL_LIM) ? FALL_LIM[7:0] : vel_dec[7:0];
        y_up    = y_ext - JUMP_S;
        y_jump  = (y_up < CEIL_S) ? CEIL_S : y_up;
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state      <= GROUNDED;
            y          <= GROUND_S[10:0];
            vel        <= 8'sd0;
            jump_req   <= 1'b0;
            airborne   <= 1'b0;
            jump_pulse <= 1'b0;
            land_pulse <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_used    <= 1'b0;
`endif
        end else begin
            jump_pulse <= 1'b0;
            land_pulse <= 1'b0;
            if (frame_tick) begin
                jump_req <= 1'b0;
                case (state)
                    GROUNDED: begin
                        if (req) begin
                            y          <= y_jump[10:0];
                            vel        <= LAUNCH_VEL;
                            state      <= RISING;
                            airborne   <= 1'b1;
                            jump_pulse <= 1'b1;
                        end
                    end
                    default: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
                        if (req && !dj_used) begin
                            y          <= y_jump[10:0];
                            vel        <= LAUNCH_VEL;
                            state      <= RISING;
                            dj_used    <= 1'b1;
                            jump_pulse <= 1'b1;
                        end else
`endif
                        if (y_n >= GROUND_S) begin
                            y          <= GROUND_S[10:0];
                            vel        <= 8'sd0;
                            state      <= GROUNDED;
                            airborne   <= 1'b0;
                            land_pulse <= 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            dj_used    <= 1'b0;
`endif
                        end else if (y_n < CEIL_S) begin
                            y     <= CEIL_S[10:0];
                            vel   <= 8'sd0;
                            state <= FALLING;
                        end else begin
                            y   <= y_n[10:0];
                            vel <= vel_n;
                            if (state == RISING && vel_n <= 8'sd0) begin
                                state <= FALLING;
                            end
                        end
                    end
                endcase
            end else if (btn_rise) begin
                jump_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_player_jump_ctrl.sv
// tb/tb_player_jump_ctrl.sv - scoreboard bench for player_jump_ctrl on a compressed frame
module tb_player_jump_ctrl;

    typedef struct packed {
        logic [9:0] y;
        logic       air;
        logic       jp;
        logic       lp;
    } exp_t;

    logic       pix_clk = 1'b0;
    logic       rst     = 1'b1;
    logic [9:0] hcount  = 10'd0;
    logic [9:0] vcount  = 10'd478;
    logic       btn_a   = 1'b0;
    logic       btn_b   = 1'b0;
    logic [9:0] y_a, y_b;
    logic       air_a, air_b, jp_a, jp_b, lp_a, lp_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic tick_da = 1'b0, pchk_a = 1'b0;
    logic tick_db = 1'b0, pchk_b = 1'b0;

    // Default physics, and a variant with ceiling at 300 and fall limit 5.
    int traj_a [25] = '{348, 337, 327, 318, 310, 303, 297, 292, 288, 285, 283, 282, 282,
                        283, 285, 288, 292, 297, 303, 310, 318, 327, 337, 348, 360};
    int traj_b [22] = '{348, 337, 327, 318, 310, 303, 300, 300, 301, 303, 306, 310, 315,
                        320, 325, 330, 335, 340, 345, 350, 355, 360};

    always #5 pix_clk = ~pix_clk;

    player_jump_ctrl dut_a (
        .pix_clk    (pix_clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .jump_btn   (btn_a),
        .player_y   (y_a),
        .airborne   (air_a),
        .jump_pulse (jp_a),
        .land_pulse (lp_a)
    );

    player_jump_ctrl #(.CEIL_Y(300), .MAX_FALL(5)) dut_b (
        .pix_clk    (pix_clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .jump_btn   (btn_b),
        .player_y   (y_b),
        .airborne   (air_b),
        .jump_pulse (jp_b),
        .land_pulse (lp_b)
    );

    // Compressed raster: 4 columns x lines 478..482, tick at (480,0).
    initial begin
        forever begin
            @(posedge pix_clk);
            #1;
            if (hcount == 10'd3) begin
                hcount = 10'd0;
                vcount = (vcount == 10'd482) ? 10'd478 : vcount + 10'd1;
            end else begin
                hcount = hcount + 10'd1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic exp_t mk(input int y, input logic air, input logic jp, input logic lp);
        exp_t e;
        e.y   = 10'(y);
        e.air = air;
        e.jp  = jp;
        e.lp  = lp;
        return e;
    endfunction

    task automatic push_idle(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) qa.push_back(mk(360, 1'b0, 1'b0, 1'b0));
            else            qb.push_back(mk(360, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) qa.push_back(mk(traj_a[i], i < 24, i == 0, i == 24));
    endtask

    task automatic push_b();
        for (int i = 0; i < 22; i++) qb.push_back(mk(traj_b[i], i < 21, i == 0, i == 21));
    endtask

    task automatic wait_pos(input logic [9:0] v, input logic [9:0] h);
        int k = 0;
        do begin
            @(posedge pix_clk);
            #2;
            k++;
        end while (!(vcount == v && hcount == h) && k < 200);
        if (!(vcount == v && hcount == h)) timeout("wait_pos");
    endtask

    task automatic wait_drain(input int which, input int left);
        int k = 0;
        while (((which == 0) ? qa.size() : qb.size()) > left && k < 2000) begin
            @(posedge pix_clk);
            #2;
            k++;
        end
        if (((which == 0) ? qa.size() : qb.size()) > left) timeout(which == 0 ? "drain_a" : "drain_b");
    endtask

    task automatic release_btns(input int n);
        repeat (n) @(posedge pix_clk);
        #2;
        btn_a = 1'b0;
        btn_b = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge pix_clk);
            if (pchk_a) begin
                chk("a_pulse_clear", int'({jp_a, lp_a}), 0);
                pchk_a = 1'b0;
            end
            if (tick_da && !rst && qa.size() > 0) begin
                ea = qa.pop_front();
                chk("a_y", int'(y_a), int'(ea.y));
                chk("a_flags", int'({air_a, jp_a, lp_a}), int'({ea.air, ea.jp, ea.lp}));
                pchk_a = 1'b1;
            end
            tick_da = (hcount == 10'd0 && vcount == 10'd480 && !rst);
        end
    end

    initial begin
        forever begin
            @(negedge pix_clk);
            if (pchk_b) begin
                chk("b_pulse_clear", int'({jp_b, lp_b}), 0);
                pchk_b = 1'b0;
            end
            if (tick_db && !rst && qb.size() > 0) begin
                eb = qb.pop_front();
                chk("b_y", int'(y_b), int'(eb.y));
                chk("b_flags", int'({air_b, jp_b, lp_b}), int'({eb.air, eb.jp, eb.lp}));
                pchk_b = 1'b1;
            end
            tick_db = (hcount == 10'd0 && vcount == 10'd480 && !rst);
        end
    end

    initial begin
        repeat (3) @(posedge pix_clk);
        @(negedge pix_clk);
        chk("rst_y_a", int'(y_a), 360);
        chk("rst_flags_a", int'({air_a, jp_a, lp_a}), 0);
        chk("rst_y_b", int'(y_b), 360);
        chk("rst_flags_b", int'({air_b, jp_b, lp_b}), 0);

        // Idle frames after reset release.
        wait_pos(10'd478, 10'd0);
        rst = 1'b0;
        push_idle(0, 3);
        push_idle(1, 3);
        wait_drain(0, 0);
        wait_drain(1, 0);

        // Mid-frame press on both instances, one quiet frame after landing.
        wait_pos(10'd478, 10'd0);
        btn_a = 1'b1;
        btn_b = 1'b1;
        push_a(25);
        push_idle(0, 1);
        push_b();
        push_idle(1, 1);
        release_btns(4);
        wait_drain(0, 0);
        wait_drain(1, 0);

        // Second press while airborne is discarded and does not linger to landing.
        wait_pos(10'd478, 10'd0);
        btn_a = 1'b1;
        push_a(25);
        push_idle(0, 2);
        release_btns(4);
        wait_drain(0, 22);
        wait_pos(10'd478, 10'd0);
        btn_a = 1'b1;
        release_btns(4);
        wait_drain(0, 0);

        // Edge detected on the tick cycle launches on that tick.
        wait_pos(10'd479, 10'd2);
        btn_a = 1'b1;
        push_a(25);
        push_idle(0, 1);
        release_btns(4);
        wait_drain(0, 0);

        // One cycle later misses this tick and launches on the next.
        wait_pos(10'd479, 10'd3);
        btn_a = 1'b1;
        push_idle(0, 1);
        push_a(25);
        push_idle(0, 1);
        release_btns(4);
        wait_drain(0, 0);

        // Reset during tick 7 of a jump.
        wait_pos(10'd478, 10'd0);
        btn_a = 1'b1;
        push_a(6);
        release_btns(4);
        wait_drain(0, 0);
        wait_pos(10'd480, 10'd0);
        rst = 1'b1;
        @(negedge pix_clk);
        chk("midrst_y", int'(y_a), 360);
        chk("midrst_flags", int'({air_a, jp_a, lp_a}), 0);
        @(posedge pix_clk);
        #2;
        rst = 1'b0;
        @(negedge pix_clk);
        chk("postrst_y", int'(y_a), 360);
        chk("postrst_land", int'(lp_a), 0);
        push_idle(0, 2);
        wait_drain(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/player_jump_ctrl.md
# player_jump_ctrl

Upstream game-logic stage for the player sprite renderer: turns a jump button into the `player_y` position consumed by the sprite bit generator. Runs a three-state jump/gravity state machine. Updates position exactly once per video frame at the start of vertical blank, so the sprite never tears mid-frame. Also emits single-cycle jump/land pulses for sound and score logic.

## Interface
- `GROUND_Y`, 360: resting top-row Y of the scaled sprite (96-px sprite on 480-line screen, feet at 456).
- `CEIL_Y`, 0: minimum allowed Y.
- `JUMP_VEL`, 12: initial upward velocity, px/frame, 1..127.
- `GRAVITY`, 1: velocity decrement per frame, 1..15.
- `MAX_FALL`, 15: downward speed limit, px/frame, 1..127.
- `UPDATE_LINE`, 480: `vcount` value on which the frame tick fires.
- `pix_clk`  in  1  pixel clock (25 MHz); the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `hcount`  in  10  current pixel column from the VGA timing generator.
- `vcount`  in  10  current line from the VGA timing generator.
- `jump_btn`  in  1  raw, asynchronous button, active-high.
- `player_y`  out  10  registered sprite top Y, driven to the sprite renderer.
- `airborne`  out  1  registered; 1 in RISING/FALLING.
- `jump_pulse`  out  1  one-cycle strobe when a jump is launched.
- `land_pulse`  out  1  one-cycle strobe on touchdown.

## Operation
- Button path: 2-FF synchronizer, then rising-edge detect.
- Each edge sets sticky `jump_req`. `jump_req` clears on every frame tick, whether the jump was consumed or ignored.
- `frame_tick = (hcount == 0) && (vcount == UPDATE_LINE)`. All physics updates happen only on this cycle.
- Internal state: `y` is 11-bit signed; `vel` is 8-bit signed, positive = upward.
- States and tick actions:
  - GROUNDED, with `jump_req` set (or edge on the same cycle): `y <= GROUND_Y - JUMP_VEL`, `vel <= JUMP_VEL - GRAVITY`, pulse `jump_pulse`, go to RISING.
  - GROUNDED, no request: hold.
  - RISING/FALLING: `y_n = y - vel`; `vel_n = max(vel - GRAVITY, -MAX_FALL)`.
- Boundary rules, evaluated in priority order:
  - `y_n >= GROUND_Y`: `y <= GROUND_Y`, `vel <= 0`, pulse `land_pulse`, go to GROUNDED.
  - `y_n < CEIL_Y`: `y <= CEIL_Y`, `vel <= 0`, go to FALLING.
  - Otherwise, in RISING: `y <= y_n`, `vel <= vel_n`, and go to FALLING when `vel_n <= 0`.
  - Otherwise, in FALLING: `y <= y_n`, `vel <= vel_n`.
- `jump_req` while airborne is discarded, unless `PLAYER_DOUBLE_JUMP_EN` is defined.
- `player_y = y[9:0]`. `y` is always within [CEIL_Y, GROUND_Y], so no wrap.

## Timing
- Reset values: `player_y = GROUND_Y`, `airborne = 0`, `jump_pulse = 0`, `land_pulse = 0`, state GROUNDED, `vel = 0`, `jump_req = 0`, sync FFs = 0.
- Button latency: button edge → `jump_req` set after 3 `pix_clk` edges. The launch then waits for the next frame tick.
- Outputs update on the `pix_clk` edge that ends the `frame_tick` cycle, and stay constant for the rest of the frame.
- `jump_pulse` and `land_pulse` are high only for the cycle after that edge.
- Edge detected on the tick cycle itself: counts for this tick.
- `rst` asserted mid-jump: immediate return to reset values. No pulse is emitted.

## Configuration
- `PLAYER_DOUBLE_JUMP_EN`, when defined:
  - A 1-bit `dj_used` flag is added.
  - A `jump_req` in RISING/FALLING with `dj_used = 0` relaunches from the current position: `y <= y - JUMP_VEL` (ceiling-clamped), `vel <= JUMP_VEL - GRAVITY`, state RISING, `dj_used <= 1`, `jump_pulse` fires.
  - `dj_used` clears on landing and on reset.
- Undefined: airborne requests are ignored; no extra flops.

## Structure
- Shared package `game_pkg`:
  - state enum (GROUNDED, RISING, FALLING);
  - screen constants (640/480);
  - sprite scaled height 96;
  - default `GROUND_Y`.
- One sub-module: `btn_sync_edge`, holding the 2-FF synchronizer and rising-edge detector. It is reused for future buttons.

## Test plan
- Reset released with no button → `player_y = 360`, `airborne = 0` across 3 frames; pulses stay low.
- Button press mid-frame:
  - next tick → `player_y = 348`, `jump_pulse` for 1 cycle;
  - tick 12 → `player_y = 282`, state FALLING;
  - tick 25 → `player_y = 360`, `land_pulse` for 1 cycle, `airborne = 0`.
- `MAX_FALL = 5`: after the apex, per-frame descent never exceeds 5 px; final `player_y = 360` exactly, with no overshoot.
- `CEIL_Y = 300` → rising clamps at `player_y = 300`, then falls starting with velocity 0.
- Press while airborne, macro undefined → trajectory identical to the single-jump case.
- Press while airborne, macro defined → relaunch; a third press is ignored.
- `rst` pulse at tick 7 of a jump → `player_y = 360` on the next cycle; no `land_pulse`.
